// File: rtl/song_sequencer.sv
// Song sequencer: steps through a note ROM and drives a tone generator's half-period and enable.
// Optional feature macro SONG_SEQUENCER_LOOP_EN replays the song endlessly instead of idling.
module song_sequencer #(
    parameter int unsigned ADDR_W   = 7,
    parameter int unsigned PER_W    = 15,
    parameter int unsigned TICK_DIV = 20910
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    output logic              rom_rd,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    output logic [PER_W-1:0]  half_period,
    output logic              tone_en,
    output logic              busy,
    output logic              done
);

    localparam int unsigned      PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StWait,
        StPlay
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [14:0]        tick_q, tick_d;
    logic [14:0]        dur_q, dur_d;
    logic [PER_W-1:0]   per_q, per_d;
    logic [31:0]        word_q, word_d;
    logic               held_q, held_d;
    logic               done_q, done_d;
    logic [31:0]        word;
    logic               song_end;
    logic               unused_rsvd;

    // ROM data is only valid the cycle after the read, so keep a copy if WAIT is paused.
    assign word        = held_q ? word_q : rom_data;
    assign unused_rsvd = word[15];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            pre_q   <= '0;
            tick_q  <= '0;
            dur_q   <= '0;
            per_q   <= '0;
            word_q  <= '0;
            held_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            pre_q   <= pre_d;
            tick_q  <= tick_d;
            dur_q   <= dur_d;
            per_q   <= per_d;
            word_q  <= word_d;
            held_q  <= held_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        pre_d    = pre_q;
        tick_d   = tick_q;
        dur_d    = dur_q;
        per_d    = per_q;
        word_d   = word_q;
        held_d   = held_q;
        done_d   = 1'b0;
        song_end = 1'b0;

        if (stop) begin
            state_d = StIdle;
            held_d  = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        addr_d  = '0;
                        state_d = StFetch;
                    end
                end
                StFetch: begin
                    if (!pause) begin
                        state_d = StWait;
                    end
                end
                StWait: begin
                    if (pause) begin
                        if (!held_q) begin
                            word_d = rom_data;
                            held_d = 1'b1;
                        end
                    end else begin
                        held_d = 1'b0;
                        if (word[31]) begin
                            song_end = 1'b1;
                        end else if (word[30:16] == '0) begin
                            addr_d  = addr_q + ADDR_W'(1);
                            state_d = StFetch;
                        end else begin
                            per_d   = PER_W'(word[14:0]);
                            dur_d   = word[30:16];
                            pre_d   = '0;
                            tick_d  = '0;
                            state_d = StPlay;
                        end
                    end
                end
                StPlay: begin
                    if (!pause) begin
                        if (pre_q == PRE_LAST) begin
                            pre_d = '0;
                            if (tick_q == dur_q - 15'd1) begin
                                if (addr_q == '1) begin
                                    song_end = 1'b1;
                                end else begin
                                    addr_d  = addr_q + ADDR_W'(1);
                                    state_d = StFetch;
                                end
                            end else begin
                                tick_d = tick_q + 15'd1;
                            end
                        end else begin
                            pre_d = pre_q + PRE_W'(1);
                        end
                    end
                end
                default: state_d = StIdle;
            endcase

            if (song_end) begin
                done_d = 1'b1;
`ifdef SONG_SEQUENCER_LOOP_EN
                addr_d  = '0;
                state_d = StFetch;
`else
                state_d = StIdle;
`endif
            end
        end
    end

    assign rom_rd      = (state_q == StFetch) && !pause && !stop;
    assign rom_addr    = addr_q;
    assign half_period = per_q;
    assign tone_en     = (state_q == StPlay) && (per_q != '0) && !pause;
    assign busy        = (state_q != StIdle);
    assign done        = done_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Randomized bench for song_sequencer: an expected per-cycle output timeline is built from the
// ROM contents, then replayed against the DUT with pause/stop/start noise applied.
module tb_song_sequencer;

    localparam int ADDR_W   = 3;
    localparam int PER_W    = 15;
    localparam int TICK_DIV = 4;
    localparam int DEPTH    = 1 << ADDR_W;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b1;
    logic              start = 1'b0;
    logic              stop  = 1'b0;
    logic              pause = 1'b0;
    logic              rom_rd;
    logic [ADDR_W-1:0] rom_addr;
    logic [31:0]       rom_data;
    logic [PER_W-1:0]  half_period;
    logic              tone_en;
    logic              busy;
    logic              done;

    logic [31:0] rom [DEPTH];

    typedef struct {
        bit rd;
        int addr;
        bit tone;
        int per;
        bit busy;
        bit done;
        bit frz;
    } ent_t;

    ent_t q[$];
    int   rd_cyc[$];
    int   m_per = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   tone_cnt, done_cnt, seen50, first60, cyc;

    always #5 clk = ~clk;

    // ROM model: word valid the cycle after a read, garbage otherwise.
    always @(posedge clk) rom_data <= rom_rd ? rom[rom_addr] : $urandom;

    song_sequencer #(
        .ADDR_W  (ADDR_W),
        .PER_W   (PER_W),
        .TICK_DIV(TICK_DIV)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .pause      (pause),
        .rom_rd     (rom_rd),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .half_period(half_period),
        .tone_en    (tone_en),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack(bit rd, int addr, bit tone, int per, bit bsy, bit dn);
        logic [31:0] v;
        v         = '0;
        v[21]     = rd;
        v[20:18]  = addr[2:0];
        v[17]     = tone;
        v[16:2]   = per[14:0];
        v[1]      = bsy;
        v[0]      = dn;
        return v;
    endfunction

    function automatic logic [31:0] dut_pack();
        return pack(rom_rd, int'(rom_addr), tone_en, int'(half_period), busy, done);
    endfunction

    function automatic void push(bit rd, int addr, bit tone, bit bsy, bit dn, bit frz);
        ent_t e;
        e.rd   = rd;
        e.addr = addr;
        e.tone = tone;
        e.per  = m_per;
        e.busy = bsy;
        e.done = dn;
        e.frz  = frz;
        q.push_back(e);
    endfunction

    // Unpaused timeline: each fetched word costs 2 clocks, a note dur*TICK_DIV more.
    function automatic void gen_song(input int passes);
        int          a;
        int          dur;
        int          guard;
        logic [31:0] w;
        bit          pend;
        pend  = 1'b0;
        guard = 0;
        for (int p = 0; p < passes; p++) begin
            a = 0;
            while (guard < 1000) begin
                guard++;
                push(1'b1, a, 1'b0, 1'b1, pend, 1'b1);
                pend = 1'b0;
                push(1'b0, a, 1'b0, 1'b1, 1'b0, 1'b1);
                w = rom[a];
                if (w[31]) break;
                dur = int'(w[30:16]);
                if (dur == 0) begin
                    a = (a + 1) % DEPTH;
                    continue;
                end
                m_per = int'(w[14:0]);
                for (int k = 0; k < dur * TICK_DIV; k++) push(1'b0, a, m_per != 0, 1'b1, 1'b0, 1'b1);
                if (a == DEPTH - 1) break;
                a++;
            end
`ifdef SONG_SEQUENCER_LOOP_EN
            pend = 1'b1;
`else
            push(1'b0, a, 1'b0, 1'b0, 1'b1, 1'b0);
            push(1'b0, a, 1'b0, 1'b0, 1'b0, 1'b0);
            push(1'b0, a, 1'b0, 1'b0, 1'b0, 1'b0);
`endif
        end
`ifdef SONG_SEQUENCER_LOOP_EN
        push(1'b1, 0, 1'b0, 1'b1, 1'b1, 1'b1);
`endif
    endfunction

    task automatic check_idle(input int addr, input int per);
        repeat (2) begin
            check("idle", dut_pack(), pack(1'b0, addr, 1'b0, per, 1'b0, 1'b0));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr_stats();
        tone_cnt = 0;
        done_cnt = 0;
        seen50   = 0;
        first60  = -1;
        cyc      = 0;
        rd_cyc.delete();
    endtask

    // pmode: 0 none, 1 random pause, 2 five-cycle pause mid first note.
    task automatic run_song(input int passes, input int pmode, input int stop_at, input bit noise);
        ent_t e;
        int   idx;
        int   pcnt;
        bit   stopped;
        idx     = 0;
        pcnt    = 0;
        stopped = 1'b0;
        gen_song(passes);
        e = q[$];
        @(posedge clk);
        #1;
        start = 1'b1;
        pause = 1'b0;
        stop  = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        while (q.size() > 0) begin
            e = q[0];
            if (pmode == 1) pause = e.frz && ($urandom_range(0, 3) == 0);
            else if (pmode == 2) pause = (idx == 5) && (pcnt < 5);
            else pause = 1'b0;
            if (pmode == 2 && pause) pcnt++;
            start = noise && e.busy && ($urandom_range(0, 7) == 0);
            stop  = (idx == stop_at);
            if (stop) start = 1'b1;
            #1;
            if (rom_rd) rd_cyc.push_back(cyc);
            if (tone_en) tone_cnt++;
            if (done) done_cnt++;
            if (half_period == 50) seen50++;
            if (half_period == 60 && first60 < 0) first60 = cyc;
            if (stop) begin
                @(posedge clk);
                #1;
                stop  = 1'b0;
                start = 1'b0;
                pause = 1'b0;
                m_per = e.per;
                q.delete();
                stopped = 1'b1;
                check_idle(e.addr, e.per);
            end else begin
                check("outputs", dut_pack(),
                      pack(e.rd && !pause, e.addr, e.tone && !pause, e.per, e.busy, e.done));
                if (pause) q[0].done = 1'b0;
                else begin
                    void'(q.pop_front());
                    idx++;
                end
                cyc++;
                @(posedge clk);
                #1;
            end
        end
        pause = 1'b0;
        start = 1'b0;
        if (!stopped) begin
            stop = 1'b1;
            @(posedge clk);
            #1;
            stop = 1'b0;
            check_idle(e.addr, m_per);
        end
    endtask

    task automatic load_basic();
        for (int i = 0; i < DEPTH; i++) rom[i] = 32'h8000_0000;
        rom[0] = {1'b0, 15'd2, 1'b0, 15'd100};
        rom[1] = {1'b0, 15'd1, 1'b0, 15'd0};
    endtask

    task automatic load_random(input bit full);
        int len;
        len = full ? DEPTH : $urandom_range(1, DEPTH - 1);
        for (int i = 0; i < DEPTH; i++) begin
            rom[i]        = $urandom;
            rom[i][31]    = 1'b0;
            rom[i][30:16] = 15'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) rom[i][14:0] = '0;
        end
        if (full) rom[DEPTH-1][30:16] = 15'($urandom_range(1, 3));
        else rom[len] = $urandom | 32'h8000_0000;
    endtask

    initial begin
        int rd_exp;
        int stop_at;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset", dut_pack(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_idle(0, 0);

        // Basic song: 8 tone clocks, gap, 4-clock rest, done.
        load_basic();
        clr_stats();
        run_song(1, 0, -1, 1'b0);
        check("tone_clocks", tone_cnt, 8);
        check("done_pulses", done_cnt, 1);
`ifdef SONG_SEQUENCER_LOOP_EN
        rd_exp = 4;
`else
        rd_exp = 3;
`endif
        check("read_count", rd_cyc.size(), rd_exp);
        if (rd_cyc.size() >= 3) begin
            check("note0_span", rd_cyc[1] - rd_cyc[0], 10);
            check("note1_span", rd_cyc[2] - rd_cyc[1], 6);
        end

        // Zero-duration word is skipped without loading its half-period.
        for (int i = 0; i < DEPTH; i++) rom[i] = 32'h8000_0000;
        rom[0] = {1'b0, 15'd0, 1'b0, 15'd50};
        rom[1] = {1'b0, 15'd1, 1'b0, 15'd60};
        clr_stats();
        run_song(1, 0, -1, 1'b0);
        check("never_50", seen50, 0);
        check("load_60_cycle", first60, 4);

        // Five paused clocks in the middle of the first note.
        load_basic();
        clr_stats();
        run_song(1, 2, -1, 1'b0);
        check("paused_tone_clocks", tone_cnt, 8);
        if (rd_cyc.size() >= 2) check("paused_note_span", rd_cyc[1] - rd_cyc[0], 15);
        else check("paused_read_count", rd_cyc.size(), 2);

        // Stop together with start during PLAY.
        clr_stats();
        run_song(1, 0, 4, 1'b0);
        check("stop_no_done", done_cnt, 0);

        // Asynchronous reset in the middle of a note.
        load_basic();
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("tone_before_rst", tone_en, 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("tone_async_rst", tone_en, 0);
        check("rst_outputs", dut_pack(), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_per = 0;
        @(posedge clk);
        #1;
        check_idle(0, 0);

`ifdef SONG_SEQUENCER_LOOP_EN
        // Endless loop: one done pulse per pass.
        load_basic();
        rom[1] = 32'h8000_0000;
        rom[0] = {1'b0, 15'd1, 1'b0, 15'd77};
        rom[1] = {1'b0, 15'd1, 1'b0, 15'd88};
        rom[2] = 32'h8000_0000;
        clr_stats();
        run_song(3, 0, -1, 1'b0);
        check("loop_done_pulses", done_cnt, 3);
`endif

        // Song ending on the last ROM address.
        load_random(1'b1);
        clr_stats();
        run_song(1, 0, -1, 1'b0);

        for (int it = 0; it < 30; it++) begin
            load_random($urandom_range(0, 4) == 0);
            stop_at = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 40) : -1;
            clr_stats();
`ifdef SONG_SEQUENCER_LOOP_EN
            run_song(2, 1, stop_at, 1'b1);
`else
            run_song(1, 1, stop_at, 1'b1);
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/song_sequencer.md
SONG_SEQUENCER -- requirements
Module: song_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 7, meaning the note ROM address width (128 entries).
REQ-002 SHALL have parameter PER_W, default 15, meaning the half-period field width in clocks.
REQ-003 SHALL have parameter TICK_DIV, default 20910, meaning clocks per duration tick.
REQ-004 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle request to play from address 0.
REQ-007 SHALL have port stop  input  1  abort playback.
REQ-008 SHALL have port pause  input  1  level; freezes playback while high.
REQ-009 SHALL have port rom_rd  output  1  ROM read strobe.
REQ-010 SHALL have port rom_addr  output  ADDR_W  ROM read address.
REQ-011 SHALL have port rom_data  input  32  ROM word, valid the cycle after rom_rd.
REQ-012 SHALL have port half_period  output  PER_W  value for the tone generator.
REQ-013 SHALL have port tone_en  output  1  tone generator enable.
REQ-014 SHALL have port busy  output  1  high in any state except IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse at song end.

Function
REQ-016 ROM word SHALL decode as: bit31 END, bits30:16 duration in ticks, bit15 reserved (ignored), bits14:0 half-period (0 = rest).
REQ-017 States SHALL be IDLE, FETCH, WAIT, PLAY; reset SHALL enter IDLE.
REQ-018 IDLE + start SHALL set addr to 0 and enter FETCH next cycle.
REQ-019 FETCH SHALL assert rom_rd for exactly one cycle with rom_addr = current addr, then enter WAIT.
REQ-020 WAIT SHALL capture rom_data: END=1 -> song end (REQ-024); duration=0 -> addr+1, FETCH; else load half_period, clear tick counters, enter PLAY.
REQ-021 In PLAY tone_en SHALL be 1 iff half_period != 0 and pause=0; tone_en SHALL be 0 in all other states.
REQ-022 PLAY SHALL last exactly duration*TICK_DIV unpaused clocks, then addr+1 and FETCH; note-to-note gap SHALL be 2 clocks with tone_en low.
REQ-023 pause=1 SHALL freeze prescaler, tick counter and FSM in every state except IDLE; rom_rd SHALL not assert while paused.
REQ-024 Song end (END word, or addr 2^ADDR_W-1 finishing its note) SHALL pulse done for one cycle and behave per REQ-030.
REQ-025 stop SHALL have priority over start and pause: next cycle IDLE, tone_en=0, no done pulse.
REQ-026 start while busy SHALL be ignored; start and song end in the same cycle SHALL not restart.
REQ-027 half_period SHALL hold its last value after a note ends until the next load.

Reset
REQ-028 rst_n low SHALL immediately force: IDLE, rom_rd=0, rom_addr=0, half_period=0, tone_en=0, busy=0, done=0, counters 0.
REQ-029 Reset mid-note SHALL silence tone_en without waiting for a clock edge; after release, idle until start.

Configuration
REQ-030 Macro SONG_SEQUENCER_LOOP_EN: defined -> song end pulses done, sets addr 0, enters FETCH (endless loop, busy stays 1); undefined -> song end pulses done and enters IDLE.

Verification
REQ-031 TICK_DIV=4, ROM {dur2/per100, dur1/per0, END}; start -> tone_en high 8 clocks with half_period=100, 2-clock gap, 4 clocks silent rest, done pulse, IDLE.
REQ-032 Word dur0/per50 at addr 0, dur1/per60 at addr 1 -> half_period never 50, 60 loads 4 clocks after start.
REQ-033 pause high 5 clocks mid-note (dur2, TICK_DIV=4) -> tone_en low during pause; note total = 8 unpaused clocks + 5.
REQ-034 stop and start in same cycle during PLAY -> IDLE next cycle, tone_en=0, done never pulses.
REQ-035 rst_n low mid-note -> tone_en 0 before next clk edge; all outputs at reset values.
REQ-036 LOOP_EN defined, 2-note song -> done pulses each pass, rom_addr returns to 0, busy stays 1 over 3 passes.
